// File: rtl/fft_peak_detect_pkg.sv
// Shared widths, types and FSM states for the FFT peak detector.
// No logic and no latency: definitions only.
package fft_peak_pkg;
  localparam int FFT_SIZE_DEF = 2048;
  localparam int BIN_W_DEF    = $clog2(FFT_SIZE_DEF);
  localparam int DATA_W_DEF   = 16;
  localparam int MAG_W_DEF    = 2*DATA_W_DEF+1;

  typedef logic [BIN_W_DEF-1:0] bin_t;
  typedef logic [MAG_W_DEF-1:0] mag_t;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_t;
endpackage

// File: rtl/fft_peak_detect_cmag_sq.sv
// Complex magnitude-squared re^2+im^2 with a valid/tag sideband; registers input then squares.
// Sum is combinational off the square register; no backpressure, accepts a sample every cycle.
module cmag_sq #(
  parameter int DATA_W = 16,
  parameter int MAG_W  = 2*DATA_W+1,
  parameter int TAG_W  = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_vld,
  input  logic [TAG_W-1:0]         i_tag,
  input  logic signed [DATA_W-1:0] i_re,
  input  logic signed [DATA_W-1:0] i_im,
  output logic                     o_vld,
  output logic [TAG_W-1:0]         o_tag,
  output logic [MAG_W-1:0]         o_mag
);
  logic                       r_vld0, r_vld1;
  logic [TAG_W-1:0]           r_tag0, r_tag1;
  logic signed [DATA_W-1:0]   r_re, r_im;
  logic [2*DATA_W-1:0]        r_sq_re, r_sq_im;
  logic signed [2*DATA_W-1:0] w_sq_re, w_sq_im;

  // A square is never negative and (-2^(W-1))^2 still fits in 2W signed bits.
  assign w_sq_re = r_re * r_re;
  assign w_sq_im = r_im * r_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld0  <= 1'b0;
      r_vld1  <= 1'b0;
      r_tag0  <= '0;
      r_tag1  <= '0;
      r_re    <= '0;
      r_im    <= '0;
      r_sq_re <= '0;
      r_sq_im <= '0;
    end else begin
      r_vld0  <= i_vld;
      r_tag0  <= i_tag;
      r_re    <= i_re;
      r_im    <= i_im;
      r_vld1  <= r_vld0;
      r_tag1  <= r_tag0;
      r_sq_re <= w_sq_re;
      r_sq_im <= w_sq_im;
    end
  end

  assign o_vld = r_vld1;
  assign o_tag = r_tag1;
  assign o_mag = MAG_W'(r_sq_re) + MAG_W'(r_sq_im);
endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame peak |X|^2 search over [min_bin,max_bin]; report 4 cycles after the last beat, tready low meanwhile.
// Optional threshold flag peak_found is built only when FFT_PEAK_THRESH_EN is defined.
module fft_peak_detect
  import fft_peak_pkg::*;
#(
  parameter int FFT_SIZE = FFT_SIZE_DEF,
  parameter int BIN_W    = $clog2(FFT_SIZE),
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAG_W    = 2*DATA_W+1
) (
  input  logic                clk_100mhz,
  input  logic                rst_n,
  input  logic [2*DATA_W-1:0] fft_tdata,
  input  logic                fft_tvalid,
  input  logic                fft_tlast,
  output logic                fft_tready,
  input  logic [BIN_W-1:0]    min_bin,
  input  logic [BIN_W-1:0]    max_bin,
  output logic [BIN_W-1:0]    peak_bin,
  output logic [MAG_W-1:0]    peak_mag,
  output logic                peak_valid,
  output logic                frame_err
`ifdef FFT_PEAK_THRESH_EN
  ,
  input  logic [MAG_W-1:0]    peak_thresh,
  output logic                peak_found
`endif
);
  state_t           r_state, w_nxt;
  logic [BIN_W-1:0] r_cnt;
  logic [1:0]       r_drn;
  logic             r_err;
  logic [BIN_W-1:0] r_run_bin;
  logic [MAG_W-1:0] r_run_mag;

  logic             w_acc, w_last_cnt, w_eof, w_in_rng;
  logic             w_mag_vld;
  logic [BIN_W-1:0] w_mag_bin;
  logic [MAG_W-1:0] w_mag;

  assign w_acc      = fft_tvalid & fft_tready;
  assign w_last_cnt = (r_cnt == BIN_W'(FFT_SIZE-1));
  assign w_eof      = w_acc & (fft_tlast | w_last_cnt);
  assign w_in_rng   = (r_cnt >= min_bin) && (r_cnt <= max_bin);

  // Out-of-range beats enter the pipeline as bubbles so the compare never sees them.
  cmag_sq #(.DATA_W(DATA_W), .MAG_W(MAG_W), .TAG_W(BIN_W)) u_cmag_sq (
    .clk   (clk_100mhz),
    .rst_n (rst_n),
    .i_vld (w_acc & w_in_rng),
    .i_tag (r_cnt),
    .i_re  (fft_tdata[DATA_W-1:0]),
    .i_im  (fft_tdata[2*DATA_W-1:DATA_W]),
    .o_vld (w_mag_vld),
    .o_tag (w_mag_bin),
    .o_mag (w_mag)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (w_eof) w_nxt = DRAIN; else if (w_acc) w_nxt = ACCUM;
      ACCUM:   if (w_eof) w_nxt = DRAIN;
      DRAIN:   if (r_drn == 2'd2) w_nxt = REPORT;
      REPORT:  w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // tready is registered from the next state so it is low throughout reset.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      fft_tready <= 1'b0;
      r_drn      <= 2'd0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      fft_tready <= (w_nxt == IDLE) || (w_nxt == ACCUM);
      r_drn      <= (r_state == DRAIN) ? r_drn + 2'd1 : 2'd0;
      if (r_state == REPORT)
        r_cnt <= '0;
      else if (w_acc)
        r_cnt <= r_cnt + 1'b1;
      if (w_eof)
        r_err <= fft_tlast ^ w_last_cnt;
    end
  end

  // Strictly-greater update keeps the earliest bin on ties.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_run_bin <= '0;
      r_run_mag <= '0;
    end else if (r_state == REPORT) begin
      r_run_bin <= '0;
      r_run_mag <= '0;
    end else if (w_mag_vld && (w_mag > r_run_mag)) begin
      r_run_bin <= w_mag_bin;
      r_run_mag <= w_mag;
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      peak_bin   <= '0;
      peak_mag   <= '0;
      peak_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      peak_valid <= (r_state == REPORT);
      frame_err  <= (r_state == REPORT) & r_err;
      if (r_state == REPORT) begin
        peak_bin <= r_run_bin;
        peak_mag <= r_run_mag;
      end
    end
  end

`ifdef FFT_PEAK_THRESH_EN
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n)
      peak_found <= 1'b0;
    else if (r_state == REPORT)
      peak_found <= (r_run_mag >= peak_thresh);
  end
`else
  // Threshold flag absent in this build.
`endif
endmodule

// File: tb/tb_fft_peak_detect.sv
// Randomized frames checked against a per-frame peak model; compare process checks every report pulse.
module tb_fft_peak_detect;
  localparam int N = 2048;

  typedef struct {
    int     bin;
    longint mag;
    bit     err;
    bit     found;
  } exp_t;

  logic        clk_100mhz;
  logic        rst_n;
  logic [31:0] fft_tdata;
  logic        fft_tvalid;
  logic        fft_tlast;
  logic        fft_tready;
  logic [10:0] min_bin;
  logic [10:0] max_bin;
  logic [10:0] peak_bin;
  logic [32:0] peak_mag;
  logic        peak_valid;
  logic        frame_err;
  logic [32:0] peak_thresh;
  logic        peak_found;

  logic signed [15:0] re_a [N];
  logic signed [15:0] im_a [N];
  exp_t exp_q [$];
  exp_t ce;
  int   n_chk  = 0;
  int   n_pass = 0;

  fft_peak_detect dut (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .fft_tdata  (fft_tdata),
    .fft_tvalid (fft_tvalid),
    .fft_tlast  (fft_tlast),
    .fft_tready (fft_tready),
    .min_bin    (min_bin),
    .max_bin    (max_bin),
    .peak_bin   (peak_bin),
    .peak_mag   (peak_mag),
    .peak_valid (peak_valid),
    .frame_err  (frame_err)
`ifdef FFT_PEAK_THRESH_EN
    ,
    .peak_thresh(peak_thresh),
    .peak_found (peak_found)
`endif
  );

`ifndef FFT_PEAK_THRESH_EN
  assign peak_found = 1'b0;
`endif

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Reference: largest |X|^2 among in-range bins, earliest on ties, (0,0) if none beats zero.
  function automatic exp_t model(input int n, input int lo, input int hi);
    exp_t e;
    longint m;
    e.bin = 0; e.mag = 0; e.err = 1'b0; e.found = 1'b0;
    for (int b = 0; b < n; b++) begin
      if (b >= lo && b <= hi) begin
        m = longint'(re_a[b]) * longint'(re_a[b]) + longint'(im_a[b]) * longint'(im_a[b]);
        if (m > e.mag) begin
          e.mag = m;
          e.bin = b;
        end
      end
    end
    return e;
  endfunction

  always @(negedge clk_100mhz) begin
    if (rst_n && peak_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_peak_valid", 1, 0);
      end else begin
        ce = exp_q.pop_front();
        chk("peak_bin", longint'(peak_bin), longint'(ce.bin));
        chk("peak_mag", longint'(peak_mag), ce.mag);
        chk("frame_err", longint'(frame_err), longint'(ce.err));
`ifdef FFT_PEAK_THRESH_EN
        chk("peak_found", longint'(peak_found), longint'(ce.found));
`endif
      end
    end else if (rst_n && frame_err) begin
      chk("frame_err_without_valid", 1, 0);
    end
  end

  task automatic fill_const(input int r, input int i);
    for (int b = 0; b < N; b++) begin
      re_a[b] = 16'(r);
      im_a[b] = 16'(i);
    end
  endtask

  task automatic fill_rand(input int amp);
    for (int b = 0; b < N; b++) begin
      if (amp == 0) begin
        re_a[b] = 16'($urandom);
        im_a[b] = 16'($urandom);
      end else begin
        re_a[b] = 16'(int'($urandom_range(2*amp)) - amp);
        im_a[b] = 16'(int'($urandom_range(2*amp)) - amp);
      end
    end
  endtask

  task automatic send_frame(input int n, input bit with_last, input int gap_pct, input bit expect_rep);
    exp_t e;
    int   wt;
    int   low;
    if (expect_rep) begin
      e = model(n, int'(min_bin), int'(max_bin));
      e.err = with_last ? (n != N) : 1'b1;
      e.found = (e.mag >= longint'(peak_thresh));
      exp_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        fft_tvalid = 1'b0;
        @(posedge clk_100mhz); #1;
      end
      fft_tvalid = 1'b1;
      fft_tdata  = {im_a[i], re_a[i]};
      fft_tlast  = with_last && (i == n-1);
      wt = 0;
      while (!fft_tready && wt < 50) begin
        wt++;
        @(posedge clk_100mhz); #1;
      end
      if (wt >= 50) begin
        chk("tready_timeout", 0, 1);
        fft_tvalid = 1'b0;
        fft_tlast  = 1'b0;
        return;
      end
      @(posedge clk_100mhz); #1;
    end
    fft_tvalid = 1'b0;
    fft_tlast  = 1'b0;
    if (expect_rep) begin
      low = 0;
      while (!fft_tready && low < 20) begin
        low++;
        @(posedge clk_100mhz); #1;
      end
      chk("tready_low_cycles", longint'(low), 4);
      chk("report_pulse_timing", longint'(peak_valid), 1);
    end
  endtask

  task automatic tone_frame();
    fill_const(10, 10);
    re_a[100] = 16'sd1000;
    im_a[100] = 16'sd0;
    min_bin = 11'd1;
    max_bin = 11'd1023;
  endtask

  initial begin
    rst_n = 1'b0; fft_tvalid = 1'b0; fft_tlast = 1'b0; fft_tdata = '0;
    min_bin = '0; max_bin = 11'd2047; peak_thresh = '0;
    repeat (3) @(posedge clk_100mhz);
    #1;
    chk("reset_tready", longint'(fft_tready), 0);
    chk("reset_peak_bin", longint'(peak_bin), 0);
    chk("reset_peak_mag", longint'(peak_mag), 0);
    chk("reset_peak_valid", longint'(peak_valid), 0);
    chk("reset_frame_err", longint'(frame_err), 0);
    rst_n = 1'b1;
    @(posedge clk_100mhz); #1;

    tone_frame();
    send_frame(N, 1'b1, 0, 1'b1);
    chk("tone_bin_literal", longint'(peak_bin), 100);
    chk("tone_mag_literal", longint'(peak_mag), 1000000);
    chk("tone_err_literal", longint'(frame_err), 0);

`ifdef FFT_PEAK_THRESH_EN
    peak_thresh = 33'd1000001;
    send_frame(N, 1'b1, 0, 1'b1);
    chk("thresh_above_literal", longint'(peak_found), 0);
    peak_thresh = 33'd1000000;
    send_frame(N, 1'b1, 0, 1'b1);
    chk("thresh_equal_literal", longint'(peak_found), 1);
`endif

    fill_const(3, 4);
    re_a[50] = 16'sd0; im_a[50] = 16'sd500;
    re_a[60] = 16'sd0; im_a[60] = 16'sd500;
    min_bin = 11'd0; max_bin = 11'd2047;
    send_frame(N, 1'b1, 0, 1'b1);
    chk("tie_first_literal", longint'(peak_bin), 50);
    min_bin = 11'd55;
    send_frame(N, 1'b1, 0, 1'b1);
    chk("tie_min55_literal", longint'(peak_bin), 60);
    min_bin = 11'd900; max_bin = 11'd10;
    send_frame(N, 1'b1, 0, 1'b1);
    chk("empty_range_bin_literal", longint'(peak_bin), 0);
    chk("empty_range_mag_literal", longint'(peak_mag), 0);

    fill_rand(100);
    re_a[7] = -16'sd32768; im_a[7] = -16'sd32768;
    min_bin = 11'd0; max_bin = 11'd2047;
    send_frame(N, 1'b1, 0, 1'b1);
    chk("extreme_mag_literal", longint'(peak_mag), 64'd2147483648);
    chk("extreme_bin_literal", longint'(peak_bin), 7);

    fill_rand(0);
    send_frame(1000, 1'b1, 0, 1'b1);
    chk("short_frame_err_literal", longint'(frame_err), 1);

    fill_rand(0);
    send_frame(N, 1'b0, 0, 1'b1);
    chk("no_tlast_err_literal", longint'(frame_err), 1);
    fill_const(1, 0);
    re_a[3] = 16'sd200; im_a[3] = 16'sd200;
    min_bin = 11'd0; max_bin = 11'd5;
    send_frame(N, 1'b1, 0, 1'b1);
    chk("after_no_tlast_bin_literal", longint'(peak_bin), 3);

    tone_frame();
    send_frame(N, 1'b1, 30, 1'b1);
    chk("gapped_tone_bin_literal", longint'(peak_bin), 100);

    for (int k = 0; k < 3; k++) begin
      fill_rand(0);
      min_bin = 11'($urandom_range(1023));
      max_bin = 11'($urandom_range(2047, 1024));
      send_frame(N, 1'b1, 20, 1'b1);
    end

    fill_rand(0);
    min_bin = 11'd0; max_bin = 11'd2047;
    send_frame(500, 1'b0, 10, 1'b0);
    rst_n = 1'b0;
    @(posedge clk_100mhz); #1;
    chk("midframe_reset_tready", longint'(fft_tready), 0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk_100mhz);
    #1;
    tone_frame();
    send_frame(N, 1'b1, 0, 1'b1);
    chk("post_reset_tone_bin_literal", longint'(peak_bin), 100);

    repeat (5) @(posedge clk_100mhz);
    #1;
    chk("pending_reports", longint'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
